// File: rtl/slice_ctrl_if.sv
// rtl/slice_ctrl_if.sv - request/capture/strobe bundle between frame source and slice_ctrl
interface slice_ctrl_if;
  logic         i_start;
  logic         i_stall;
  logic         i_code_rate;
  logic [319:0] i_encoder_data_frame;
  logic [383:0] i_decoder_data_frame;
  logic [319:0] o_encoder_data_frame;
  logic [383:0] o_decoder_data_frame;
  logic         o_code_rate;
  logic         o_rst_s;
  logic         o_en_s;
  logic         o_tx_valid;
  logic         o_rx_valid;
  logic         o_busy;
  logic         o_done;
  logic         o_overrun;

  modport master (
    output i_start, i_stall, i_code_rate, i_encoder_data_frame, i_decoder_data_frame,
    input  o_encoder_data_frame, o_decoder_data_frame, o_code_rate, o_rst_s, o_en_s,
           o_tx_valid, o_rx_valid, o_busy, o_done, o_overrun
  );

  modport slave (
    input  i_start, i_stall, i_code_rate, i_encoder_data_frame, i_decoder_data_frame,
    output o_encoder_data_frame, o_decoder_data_frame, o_code_rate, o_rst_s, o_en_s,
           o_tx_valid, o_rx_valid, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/slice_ctrl.sv
// rtl/slice_ctrl.sv - frame slicer sequencer: capture, one-frame load/enable run, valid strobes
module slice_ctrl (
  input  logic        clk,
  input  logic        rst,
  slice_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [7:0] LAST_BEAT = 8'd159;
  localparam logic [6:0] RX_SYMS   = 7'd64;

  logic [1:0]   state_q, state_d;
  logic [7:0]   tx_beat_q, tx_beat_d;
  logic [6:0]   rx_sym_q, rx_sym_d;
  logic         rx_toggle_q, rx_toggle_d;
  logic         tx_valid_q, tx_valid_d;
  logic         rx_valid_q, rx_valid_d;
  logic         overrun_q, overrun_d;
  logic         code_rate_q, code_rate_d;
  logic [319:0] enc_q, enc_d;
  logic [383:0] dec_q, dec_d;

  logic busy, en, rx_start;

  always_comb begin
    busy     = (state_q != S_IDLE);
    en       = (state_q == S_RUN) & ~bus.i_stall;
    // a new RX symbol begins on every other enabled cycle until 64 have started
    rx_start = en & ~rx_toggle_q & (rx_sym_q < RX_SYMS);

    state_d     = state_q;
    tx_beat_d   = tx_beat_q;
    rx_sym_d    = rx_sym_q;
    rx_toggle_d = rx_toggle_q;
    overrun_d   = overrun_q;
    code_rate_d = code_rate_q;
    enc_d       = enc_q;
    dec_d       = dec_q;
    tx_valid_d  = en;
    rx_valid_d  = rx_start;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d     = S_LOAD;
          code_rate_d = bus.i_code_rate;
          enc_d       = bus.i_encoder_data_frame;
          dec_d       = bus.i_decoder_data_frame;
          tx_beat_d   = 8'd0;
          rx_sym_d    = 7'd0;
          rx_toggle_d = 1'b0;
          overrun_d   = 1'b0;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (en) begin
          tx_beat_d   = tx_beat_q + 8'd1;
          rx_toggle_d = ~rx_toggle_q;
          if (rx_start) rx_sym_d = rx_sym_q + 7'd1;
          if (tx_beat_q == LAST_BEAT) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (busy && bus.i_start) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tx_beat_q   <= 8'd0;
      rx_sym_q    <= 7'd0;
      rx_toggle_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      code_rate_q <= 1'b0;
      enc_q       <= '0;
      dec_q       <= '0;
    end else begin
      state_q     <= state_d;
      tx_beat_q   <= tx_beat_d;
      rx_sym_q    <= rx_sym_d;
      rx_toggle_q <= rx_toggle_d;
      tx_valid_q  <= tx_valid_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      code_rate_q <= code_rate_d;
      enc_q       <= enc_d;
      dec_q       <= dec_d;
    end
  end

  // slicer load is held low through LOAD so it presets from the already-latched rate
  assign bus.o_rst_s              = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign bus.o_en_s               = en;
  assign bus.o_tx_valid           = tx_valid_q;
  assign bus.o_rx_valid           = rx_valid_q;
  assign bus.o_busy               = busy;
  assign bus.o_done               = (state_q == S_DRAIN);
  assign bus.o_overrun            = overrun_q;
  assign bus.o_code_rate          = code_rate_q;
  assign bus.o_encoder_data_frame = enc_q;
  assign bus.o_decoder_data_frame = dec_q;
endmodule

// File: tb/tb_slice_ctrl.sv
// tb/tb_slice_ctrl.sv - scoreboard bench for slice_ctrl frame timing, stall, overrun and reset
module tb_slice_ctrl;
  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;

  typedef struct {
    int   cyc;
    logic tx;
    logic rx;
    logic dn;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   en_cnt = 0;
  ev_t  exp_q[$];
  ev_t  mon_e;

  slice_ctrl_if bus ();
  slice_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: every strobe the DUT shows must match the next expected event
  always @(negedge clk) begin
    if (bus.o_en_s) en_cnt++;
    if (bus.o_tx_valid || bus.o_rx_valid || bus.o_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d actual=%b%b%b required=none",
                 cyc, bus.o_tx_valid, bus.o_rx_valid, bus.o_done);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_cycle", 384'(cyc), 384'(mon_e.cyc));
        check("strobe_flags", {bus.o_tx_valid, bus.o_rx_valid, bus.o_done},
              {mon_e.tx, mon_e.rx, mon_e.dn});
      end
    end
  end

  function automatic bit is_stall(input int rel, input int st_a, input int st_n, input int st_b);
    return ((rel >= st_a) && (rel < st_a + st_n)) || (st_b != 0 && rel == st_b);
  endfunction

  // entered mid-cycle with the DUT idle; start is accepted at the next edge (E0)
  task automatic run_frame(input logic rate, input logic [319:0] enc, input logic [383:0] dec,
                           input int st_a, input int st_n, input int st_b,
                           input int bz_a, input int bz_b, input bit keep, input int abort_at);
    int c, k, len, c0;
    bus.i_start = 1'b1;
    bus.i_stall = 1'b0;
    bus.i_code_rate = rate;
    bus.i_encoder_data_frame = enc;
    bus.i_decoder_data_frame = dec;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.i_code_rate = ~rate;
    bus.i_encoder_data_frame = ~enc;
    bus.i_decoder_data_frame = ~dec;
    // expected strobes: k-th enabled beat at rel cycle c gives strobes at rel c+1
    c = 2;
    k = 0;
    while (k < 160) begin
      if (!is_stall(c, st_a, st_n, st_b)) begin
        exp_q.push_back('{c0 + c, 1'b1, (k % 2 == 0) && (k < 128), k == 159});
        k++;
      end
      c++;
    end
    len = c + 1;
    en_cnt = 0;
    for (int rel = 1; rel < len; rel++) begin
      bus.i_stall = is_stall(rel, st_a, st_n, st_b);
      bus.i_start = keep || rel == bz_a || rel == bz_b;
      if (rel == abort_at) begin
        rst = 1'b0;
        #1;
        check("rst_busy", 384'(bus.o_busy), 384'(0));
        check("rst_en_done", {bus.o_en_s, bus.o_done, bus.o_rst_s}, 384'(0));
        check("rst_valids", {bus.o_tx_valid, bus.o_rx_valid, bus.o_overrun}, 384'(0));
        check("rst_enc", 384'(bus.o_encoder_data_frame), 384'(0));
        check("rst_dec_rate", {bus.o_decoder_data_frame[383:1], bus.o_code_rate}, 384'(0));
        exp_q.delete();
        bus.i_start = 1'b0;
        bus.i_stall = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      if (rel == 1) begin
        check("load_busy", 384'(bus.o_busy), 384'(1));
        check("load_rst_s_en", {bus.o_rst_s, bus.o_en_s}, 384'(0));
        check("load_overrun", 384'(bus.o_overrun), 384'(0));
        check("load_rate", 384'(bus.o_code_rate), 384'(rate));
        check("load_enc", 384'(bus.o_encoder_data_frame), 384'(enc));
        check("load_dec", bus.o_decoder_data_frame, dec);
      end
      if (rel == 2) check("run_rst_s", 384'(bus.o_rst_s), 384'(1));
      if (bz_a != 0 && rel == bz_a + 1) check("overrun_set", 384'(bus.o_overrun), 384'(1));
      if (rel == len - 1) begin
        check("drain_rate", 384'(bus.o_code_rate), 384'(rate));
        check("drain_enc", 384'(bus.o_encoder_data_frame), 384'(enc));
        check("drain_dec", bus.o_decoder_data_frame, dec);
      end
      @(posedge clk);
      #1;
    end
    bus.i_stall = 1'b0;
    bus.i_start = keep;
    @(negedge clk);
    check("idle_busy", 384'(bus.o_busy), 384'(0));
    check("idle_rst_s", 384'(bus.o_rst_s), 384'(0));
    check("en_count", 384'(en_cnt), 384'(160));
    check("pending_events", 384'(exp_q.size()), 384'(0));
    check("idle_overrun", 384'(bus.o_overrun), 384'(keep || bz_a != 0));
  endtask

  logic [319:0] enc_a, enc_b;
  logic [383:0] dec_a, dec_b;

  initial begin
    bus.i_start = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_code_rate = 1'b0;
    bus.i_encoder_data_frame = '1;
    bus.i_decoder_data_frame = '1;
    enc_a = {10{32'hA5C3_0F1E}};
    enc_b = {10{32'h1234_5678}};
    dec_a = {12{32'hFC00_9137}};
    dec_b = {12{32'h0DEF_ACE5}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy_done", {bus.o_busy, bus.o_done, bus.o_en_s, bus.o_rst_s}, 384'(0));
    check("reset_valids", {bus.o_tx_valid, bus.o_rx_valid, bus.o_overrun, bus.o_code_rate}, 384'(0));
    check("reset_frames", bus.o_decoder_data_frame | 384'(bus.o_encoder_data_frame), 384'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame(CODE_RATE_2, enc_a, dec_a, 0, 0, 0, 0, 0, 1'b0, 0);
    run_frame(CODE_RATE_3, enc_b, dec_b, 0, 0, 0, 0, 0, 1'b0, 0);
    check("rate3_first_sym", 384'(bus.o_decoder_data_frame[383:378]), 384'(6'h03));
    run_frame(CODE_RATE_2, enc_b, dec_a, 10, 5, 40, 0, 0, 1'b0, 0);
    run_frame(CODE_RATE_3, enc_a, dec_b, 0, 0, 0, 50, 162, 1'b0, 0);
    run_frame(CODE_RATE_2, enc_b, dec_b, 0, 0, 0, 0, 0, 1'b0, 0);
    run_frame(CODE_RATE_3, enc_a, dec_a, 0, 0, 0, 0, 0, 1'b0, 80);
    @(negedge clk);
    check("post_reset_idle", {bus.o_busy, bus.o_done, bus.o_overrun}, 384'(0));
    run_frame(CODE_RATE_2, enc_a, dec_b, 0, 0, 0, 0, 0, 1'b0, 0);
    run_frame(CODE_RATE_3, enc_b, dec_a, 0, 0, 0, 0, 0, 1'b1, 0);
    run_frame(CODE_RATE_2, enc_a, dec_b, 0, 0, 0, 0, 0, 1'b1, 0);
    run_frame(CODE_RATE_3, enc_b, dec_b, 0, 0, 0, 0, 0, 1'b0, 0);
    bus.i_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("final_idle", 384'(bus.o_busy), 384'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
